muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequential multiply/divide unit with architectural HI/LO registers.
// Multiplication is radix-2 shift-add and division is restoring, one bit per cycle.
// Both work on operand magnitudes; the sign is corrected in a final FIX cycle.
// Optional feature macro: MULDIV_DIV_EN (defined = divide datapath present).
// Without it, a divide request completes at once and does nothing.
module muldiv_ctrl (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        WriteHI,
    input  logic        WriteLO,
    input  logic [31:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] acc_hi_q, acc_hi_d;   // product high half / partial remainder
    logic [31:0] acc_lo_q, acc_lo_d;   // multiplier shifting out / dividend shifting into quotient
    logic [31:0] mcand_q, mcand_d;     // multiplicand or divisor magnitude
    logic        sign_res_q, sign_res_d; // negate product or quotient in FIX
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // Operand magnitudes: Op[0]=0 selects the signed flavour
    logic        op_signed;
    logic [31:0] a_mag, b_mag;
    assign op_signed = ~Op[0];
    assign a_mag     = (op_signed && A[31]) ? -A : A;
    assign b_mag     = (op_signed && B[31]) ? -B : B;

    // Shift-add step: add multiplicand when the multiplier LSB is set, then shift right
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : 33'd0);

    // Sign-corrected 64-bit product
    logic [63:0] prod_fix;
    assign prod_fix = sign_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

`ifdef MULDIV_DIV_EN
    logic op_div_q, op_div_d;
    logic sign_rem_q, sign_rem_d;    // remainder follows the dividend sign
    logic div0_q, div0_d;            // divisor was zero: leave HI/LO alone
    logic divzero_q, divzero_d;

    // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
    // The true difference is below the divisor, so 32-bit wrap arithmetic is exact.
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [31:0] quo_fix, rem_fix;
    assign div_shift = {acc_hi_q, acc_lo_q[31]};
    assign div_ge    = div_shift >= {1'b0, mcand_q};
    assign div_sub   = div_shift[31:0] - mcand_q;
    assign quo_fix   = sign_res_q ? -acc_lo_q : acc_lo_q;
    assign rem_fix   = sign_rem_q ? -acc_hi_q : acc_hi_q;
`endif

    // State and datapath registers; reset clears everything immediately
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 6'd0;
            acc_hi_q   <= 32'd0;
            acc_lo_q   <= 32'd0;
            mcand_q    <= 32'd0;
            sign_res_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
            op_div_q   <= 1'b0;
            sign_rem_q <= 1'b0;
            div0_q     <= 1'b0;
            divzero_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            mcand_q    <= mcand_d;
            sign_res_q <= sign_res_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
`ifdef MULDIV_DIV_EN
            op_div_q   <= op_div_d;
            sign_rem_q <= sign_rem_d;
            div0_q     <= div0_d;
            divzero_q  <= divzero_d;
`endif
        end
    end

    // Next-state, datapath step and HI/LO update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        mcand_d    = mcand_q;
        sign_res_d = sign_res_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
`ifdef MULDIV_DIV_EN
        op_div_d   = op_div_q;
        sign_rem_d = sign_rem_q;
        div0_d     = div0_q;
        divzero_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // MTHI/MTLO only while idle; a same-edge Start still proceeds
                if (WriteHI) hi_d = WriteData;
                if (WriteLO) lo_d = WriteData;
`ifdef MULDIV_DIV_EN
                if (Start) begin
                    state_d    = S_RUN;
                    cnt_d      = 6'd0;
                    acc_hi_d   = 32'd0;
                    acc_lo_d   = Op[1] ? a_mag : b_mag;
                    mcand_d    = Op[1] ? b_mag : a_mag;
                    sign_res_d = op_signed & (A[31] ^ B[31]);
                    op_div_d   = Op[1];
                    sign_rem_d = op_signed & A[31];
                    div0_d     = Op[1] & (B == 32'd0);
                end
`else
                if (Start && Op[1]) begin
                    done_d = 1'b1;
                end else if (Start) begin
                    state_d    = S_RUN;
                    cnt_d      = 6'd0;
                    acc_hi_d   = 32'd0;
                    acc_lo_d   = b_mag;
                    mcand_d    = a_mag;
                    sign_res_d = op_signed & (A[31] ^ B[31]);
                end
`endif
            end
            S_RUN: begin
                cnt_d    = cnt_q + 6'd1;
                acc_hi_d = mul_sum[32:1];
                acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
`ifdef MULDIV_DIV_EN
                if (op_div_q) begin
                    acc_hi_d = div_ge ? div_sub : div_shift[31:0];
                    acc_lo_d = {acc_lo_q[30:0], div_ge};
                end
`endif
                if (cnt_q == 6'd31) begin
                    state_d = S_FIX;
                    cnt_d   = 6'd0;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                divzero_d = div0_q;
                if (!op_div_q) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (!div0_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
`else
                hi_d = prod_fix[63:32];
                lo_d = prod_fix[31:0];
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Busy   = (state_q != S_IDLE);
    assign Done   = done_q;
    assign HI_out = hi_q;
    assign LO_out = lo_q;
`ifdef MULDIV_DIV_EN
    assign DivZero = divzero_q;
`else
    assign DivZero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.
// Observation index n: n=1 is the cycle right after the accepting edge.
module tb_muldiv_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, Start, WriteHI, WriteLO;
    logic [1:0]  Op;
    logic [31:0] A, B, WriteData;
    logic        Busy, Done, DivZero;
    logic [31:0] HI_out, LO_out;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    muldiv_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .WriteHI(WriteHI), .WriteLO(WriteLO), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .DivZero(DivZero), .HI_out(HI_out), .LO_out(LO_out)
    );

    always #5 Clk = ~Clk;

    // Called at a falling edge; Start is seen at the next rising edge. Returns at n=1.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Op = op; A = a; B = b; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Advance until Done is seen (bounded); n = observation index of Done, -1 on timeout
    task automatic wait_done(input int n0, output int n, output int busy_n);
        n = n0; busy_n = 0;
        while (Done !== 1'b1 && n < 100) begin
            if (Busy === 1'b1) busy_n++;
            @(negedge Clk);
            n++;
        end
        if (Done !== 1'b1) n = -1;
    endtask

    task automatic write_reg(input logic hi, input logic lo, input logic [31:0] d);
        WriteHI = hi; WriteLO = lo; WriteData = d;
        @(negedge Clk);
        WriteHI = 1'b0; WriteLO = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Start = 1'b0; WriteHI = 1'b0; WriteLO = 1'b0;
        Op = 2'b00; A = 32'd0; B = 32'd0; WriteData = 32'd0;
        #3;  // before any clock edge: reset must act asynchronously
        tests++;
        if ({Busy, Done, DivZero} !== 3'b000) begin
            fails++; $display("FAIL reset_flags: Busy/Done/DivZero=%b expected 000", {Busy, Done, DivZero});
        end
        tests++;
        if ({HI_out, LO_out} !== 64'd0) begin
            fails++; $display("FAIL reset_hilo: HI/LO=%h expected 0", {HI_out, LO_out});
        end
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Started right at reset release: first rising edge with Reset low must accept
    task automatic test_multu_max;
        int n, bn;
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(1, n, bn);
        tests++;
        if (n !== 34) begin fails++; $display("FAIL multu_max_latency: done at n=%0d expected 34", n); end
        tests++;
        if (bn !== 33) begin fails++; $display("FAIL multu_max_busy: busy cycles=%0d expected 33", bn); end
        tests++;
        if ({HI_out, LO_out, Busy, DivZero} !== {32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0}) begin
            fails++; $display("FAIL multu_max_result: HI=%h LO=%h Busy=%b DivZero=%b expected fffffffe 00000001 0 0",
                              HI_out, LO_out, Busy, DivZero);
        end
        @(negedge Clk);
        tests++;
        if (Done !== 1'b0) begin fails++; $display("FAIL multu_max_pulse: Done=%b expected 0", Done); end
    endtask

    task automatic test_mult_table;
        vec_t mv[6];
        int n, bn;
        mv[0] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        mv[1] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        mv[2] = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        mv[3] = '{OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
        mv[4] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        mv[5] = '{OP_MULT,  32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000};
        for (int i = 0; i < 6; i++) begin
            start_op(mv[i].op, mv[i].a, mv[i].b);
            wait_done(1, n, bn);
            tests++;
            if (n !== 34 || HI_out !== mv[i].hi || LO_out !== mv[i].lo) begin
                fails++;
                $display("FAIL mult_vec%0d: n=%0d HI=%h LO=%h expected n=34 HI=%h LO=%h",
                         i, n, HI_out, LO_out, mv[i].hi, mv[i].lo);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_back_to_back;
        int n, bn;
        start_op(OP_MULT, 32'hFFFFFFFD, 32'd5);
        wait_done(1, n, bn);
        tests++;
        if (HI_out !== 32'hFFFFFFFF || LO_out !== 32'hFFFFFFF1) begin
            fails++; $display("FAIL mult_neg3x5: HI=%h LO=%h expected ffffffff fffffff1", HI_out, LO_out);
        end
        // Start while Done is high: must be accepted with no idle gap
`ifdef MULDIV_DIV_EN
        start_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
`else
        start_op(OP_MULTU, 32'd3, 32'd4);
`endif
        tests++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
            fails++; $display("FAIL b2b_accept: Busy=%b Done=%b expected 1 0", Busy, Done);
        end
        wait_done(1, n, bn);
        tests++;
`ifdef MULDIV_DIV_EN
        if (n !== 34 || LO_out !== 32'hFFFFFFFD || HI_out !== 32'hFFFFFFFF) begin
            fails++; $display("FAIL b2b_div: n=%0d HI=%h LO=%h expected n=34 ffffffff fffffffd", n, HI_out, LO_out);
        end
`else
        if (n !== 34 || LO_out !== 32'd12 || HI_out !== 32'd0) begin
            fails++; $display("FAIL b2b_multu: n=%0d HI=%h LO=%h expected n=34 0 c", n, HI_out, LO_out);
        end
`endif
        @(negedge Clk);
    endtask

    task automatic test_write_hilo;
        write_reg(1'b0, 1'b1, 32'h0000CAFE);
        write_reg(1'b1, 1'b0, 32'h00001234);
        tests++;
        if (HI_out !== 32'h1234 || LO_out !== 32'hCAFE) begin
            fails++; $display("FAIL write_hi: HI=%h LO=%h expected 1234 cafe", HI_out, LO_out);
        end
        write_reg(1'b0, 1'b1, 32'h00005678);
        tests++;
        if (HI_out !== 32'h1234 || LO_out !== 32'h5678) begin
            fails++; $display("FAIL write_lo: HI=%h LO=%h expected 1234 5678", HI_out, LO_out);
        end
        write_reg(1'b1, 1'b1, 32'h0000BEEF);
        tests++;
        if (HI_out !== 32'hBEEF || LO_out !== 32'hBEEF) begin
            fails++; $display("FAIL write_both: HI=%h LO=%h expected beef beef", HI_out, LO_out);
        end
    endtask

    task automatic test_busy_ignore;
        int n, bn;
        write_reg(1'b0, 1'b1, 32'h00000F0F);
        start_op(OP_MULTU, 32'd7, 32'd9);
        repeat (9) @(negedge Clk);          // now n=10
        Op = OP_MULTU; A = 32'd1; B = 32'd1; Start = 1'b1;
        WriteLO = 1'b1; WriteData = 32'h0000AAAA;
        @(negedge Clk);                      // n=11
        Start = 1'b0; WriteLO = 1'b0;
        tests++;
        if (LO_out !== 32'h0F0F || Busy !== 1'b1) begin
            fails++; $display("FAIL busy_write_ignored: LO=%h Busy=%b expected 0f0f 1", LO_out, Busy);
        end
        wait_done(11, n, bn);
        tests++;
        if (n !== 34 || HI_out !== 32'd0 || LO_out !== 32'd63) begin
            fails++; $display("FAIL busy_start_ignored: n=%0d HI=%h LO=%h expected n=34 0 3f", n, HI_out, LO_out);
        end
        @(negedge Clk);
        tests++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            fails++; $display("FAIL busy_no_queue: Busy=%b Done=%b expected 0 0", Busy, Done);
        end
    endtask

    task automatic test_write_with_start;
        int n, bn;
        WriteHI = 1'b1; WriteData = 32'h0000DEAD;
        start_op(OP_MULTU, 32'd2, 32'd3);
        WriteHI = 1'b0;
        tests++;
        if (HI_out !== 32'hDEAD || Busy !== 1'b1) begin
            fails++; $display("FAIL write_start_same_edge: HI=%h Busy=%b expected dead 1", HI_out, Busy);
        end
        wait_done(1, n, bn);
        tests++;
        if (n !== 34 || HI_out !== 32'd0 || LO_out !== 32'd6) begin
            fails++; $display("FAIL write_start_result: n=%0d HI=%h LO=%h expected n=34 0 6", n, HI_out, LO_out);
        end
        @(negedge Clk);
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_divide;
        vec_t dv[7];
        int n, bn;
        dv[0] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        dv[1] = '{OP_DIVU, 32'd50,       32'd7,        32'h00000001, 32'h00000007};
        dv[2] = '{OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        dv[3] = '{OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
        dv[4] = '{OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
        dv[5] = '{OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        dv[6] = '{OP_DIV,  32'h80000000, 32'd2,        32'h00000000, 32'hC0000000};
        for (int i = 0; i < 7; i++) begin
            start_op(dv[i].op, dv[i].a, dv[i].b);
            wait_done(1, n, bn);
            tests++;
            if (n !== 34 || HI_out !== dv[i].hi || LO_out !== dv[i].lo || DivZero !== 1'b0) begin
                fails++;
                $display("FAIL div_vec%0d: n=%0d HI=%h LO=%h DivZero=%b expected n=34 HI=%h LO=%h DivZero=0",
                         i, n, HI_out, LO_out, DivZero, dv[i].hi, dv[i].lo);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_divzero;
        int n, bn;
        write_reg(1'b1, 1'b0, 32'h00001234);
        write_reg(1'b0, 1'b1, 32'h00005678);
        start_op(OP_DIVU, 32'd100, 32'd0);
        wait_done(1, n, bn);
        tests++;
        if (n !== 34 || DivZero !== 1'b1 || HI_out !== 32'h1234 || LO_out !== 32'h5678) begin
            fails++; $display("FAIL divzero: n=%0d DivZero=%b HI=%h LO=%h expected n=34 1 1234 5678",
                              n, DivZero, HI_out, LO_out);
        end
        @(negedge Clk);
        tests++;
        if (DivZero !== 1'b0 || Done !== 1'b0) begin
            fails++; $display("FAIL divzero_pulse: DivZero=%b Done=%b expected 0 0", DivZero, Done);
        end
    endtask
`else
    task automatic test_nodiv;
        write_reg(1'b1, 1'b0, 32'h00000055);
        write_reg(1'b0, 1'b1, 32'h00000066);
        start_op(OP_DIV, 32'd10, 32'd2);
        tests++;
        if (Done !== 1'b1 || Busy !== 1'b0 || DivZero !== 1'b0) begin
            fails++; $display("FAIL nodiv_done: Done=%b Busy=%b DivZero=%b expected 1 0 0", Done, Busy, DivZero);
        end
        tests++;
        if (HI_out !== 32'h55 || LO_out !== 32'h66) begin
            fails++; $display("FAIL nodiv_hilo: HI=%h LO=%h expected 55 66", HI_out, LO_out);
        end
        @(negedge Clk);
        tests++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            fails++; $display("FAIL nodiv_pulse: Done=%b Busy=%b expected 0 0", Done, Busy);
        end
    endtask
`endif

    task automatic test_reset_mid;
        int done_seen;
        write_reg(1'b1, 1'b1, 32'h00000011);
`ifdef MULDIV_DIV_EN
        start_op(OP_DIVU, 32'd50, 32'd7);
`else
        start_op(OP_MULTU, 32'd50, 32'd7);
`endif
        repeat (14) @(negedge Clk);          // n=15
        #2 Reset = 1'b1;
        #1;
        tests++;
        if (Busy !== 1'b0 || Done !== 1'b0 || HI_out !== 32'd0 || LO_out !== 32'd0) begin
            fails++; $display("FAIL reset_mid_async: Busy=%b Done=%b HI=%h LO=%h expected 0 0 0 0",
                              Busy, Done, HI_out, LO_out);
        end
        repeat (4) @(negedge Clk);
        Reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done === 1'b1 || Busy === 1'b1) done_seen++;
        end
        tests++;
        if (done_seen !== 0 || HI_out !== 32'd0 || LO_out !== 32'd0) begin
            fails++; $display("FAIL reset_mid_abort: done/busy cycles=%0d HI=%h LO=%h expected 0 0 0",
                              done_seen, HI_out, LO_out);
        end
    endtask

    initial begin
        test_reset;
        test_multu_max;
        test_mult_table;
        test_back_to_back;
        test_write_hilo;
        test_busy_ignore;
        test_write_with_start;
`ifdef MULDIV_DIV_EN
        test_divide;
        test_divzero;
`else
        test_nodiv;
`endif
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
